// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared constants and types for the elevator call scheduler
package elevator_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 4;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam logic [FLOOR_W-1:0] FLOOR_G   = FLOOR_W'(1);
  localparam logic [FLOOR_W-1:0] FLOOR_TOP = FLOOR_W'(NUM_FLOORS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE_UP,
    ST_MOVE_DOWN,
    ST_DWELL
  } state_t;

endpackage

// File: rtl/floor_select.sv
// rtl/floor_select.sv - nearest pending floor above/below the car and at the car
module floor_select
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
  input  logic [NUM_FLOORS:1] pending,
  input  logic [FLOOR_W-1:0]  current_floor,
  output logic [FLOOR_W-1:0]  above_floor,
  output logic                above_valid,
  output logic [FLOOR_W-1:0]  below_floor,
  output logic                below_valid,
  output logic                here
);

  // Scan downward for the lowest call above, upward for the highest call below.
  always_comb begin
    above_floor = '0;
    above_valid = 1'b0;
    below_floor = '0;
    below_valid = 1'b0;
    here        = 1'b0;
    for (int i = NUM_FLOORS; i >= 1; i--) begin
      if (pending[i] && (FLOOR_W'(i) > current_floor)) begin
        above_floor = FLOOR_W'(i);
        above_valid = 1'b1;
      end
    end
    for (int i = 1; i <= NUM_FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i) < current_floor)) begin
        below_floor = FLOOR_W'(i);
        below_valid = 1'b1;
      end
      if (pending[i] && (FLOOR_W'(i) == current_floor)) begin
        here = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - SCAN call scheduler with door dwell for an 8-floor car
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W      = elevator_pkg::FLOOR_W,
  parameter int DWELL_CYCLES = 16
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [NUM_FLOORS:1] call_req,
  input  logic [FLOOR_W-1:0]  current_floor,
  input  logic                arrived,
  output logic [FLOOR_W-1:0]  target_floor,
  output logic                target_valid,
  output logic [1:0]          dir,
  output logic                door_open,
  output logic [NUM_FLOORS:1] pending,
  output logic                fault
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      dwell_cnt, cnt_nxt;
  logic [FLOOR_W-1:0]    target_nxt;
  logic                  tvalid_nxt, door_nxt, fault_nxt, svc;
  logic [1:0]            dir_nxt;
  logic [NUM_FLOORS:1]   pending_nxt;
  logic                  call_here;

  logic [FLOOR_W-1:0]    above_floor, below_floor;
  logic                  above_valid, below_valid, here;
  logic [FLOOR_W-1:0]    dist_up, dist_dn;
  logic                  floor_ok;

  floor_select #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_floor_select (
    .pending       (pending),
    .current_floor (current_floor),
    .above_floor   (above_floor),
    .above_valid   (above_valid),
    .below_floor   (below_floor),
    .below_valid   (below_valid),
    .here          (here)
  );

  assign floor_ok = (current_floor != '0) && (current_floor <= FLOOR_W'(NUM_FLOORS));
  assign dist_up  = above_floor - current_floor;
  assign dist_dn  = current_floor - below_floor;

  // A fresh call at the floor the car is sitting on.
  always_comb begin
    call_here = 1'b0;
    for (int i = 1; i <= NUM_FLOORS; i++) begin
      if (call_req[i] && (FLOOR_W'(i) == current_floor)) call_here = 1'b1;
    end
  end

  // Call latching: service and door-open absorption both beat a same-cycle call.
  always_comb begin
    pending_nxt = pending;
    for (int i = 1; i <= NUM_FLOORS; i++) begin
      if (call_req[i]) pending_nxt[i] = 1'b1;
      if ((FLOOR_W'(i) == current_floor) && (svc || (state == ST_DWELL))) pending_nxt[i] = 1'b0;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_nxt  = state;
    target_nxt = target_floor;
    tvalid_nxt = target_valid;
    dir_nxt    = dir;
    door_nxt   = door_open;
    cnt_nxt    = dwell_cnt;
    fault_nxt  = fault;
    svc        = 1'b0;

    if (arrived && (current_floor != target_floor)) fault_nxt = 1'b1;

    if (!floor_ok) begin
      // Bad floor report: hold everything, drop the target for this cycle.
      fault_nxt  = 1'b1;
      tvalid_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tvalid_nxt = 1'b0;
          door_nxt   = 1'b0;
          dir_nxt    = DIR_IDLE;
          if (here) begin
            svc       = 1'b1;
            state_nxt = ST_DWELL;
            door_nxt  = 1'b1;
            cnt_nxt   = DWELL_LOAD;
          end else if (above_valid && (!below_valid || (dist_up <= dist_dn))) begin
            state_nxt  = ST_MOVE_UP;
            dir_nxt    = DIR_UP;
            target_nxt = above_floor;
            tvalid_nxt = 1'b1;
          end else if (below_valid) begin
            state_nxt  = ST_MOVE_DOWN;
            dir_nxt    = DIR_DOWN;
            target_nxt = below_floor;
            tvalid_nxt = 1'b1;
          end
        end

        ST_MOVE_UP, ST_MOVE_DOWN: begin
          if (arrived && (current_floor == target_floor)) begin
            svc        = 1'b1;
            state_nxt  = ST_DWELL;
            door_nxt   = 1'b1;
            tvalid_nxt = 1'b0;
            cnt_nxt    = DWELL_LOAD;
          end else if (here) begin
            // Car is level with a pending floor: hold it there until arrival.
            target_nxt = current_floor;
            tvalid_nxt = 1'b1;
          end else if ((state == ST_MOVE_UP) && above_valid) begin
            target_nxt = above_floor;
            tvalid_nxt = 1'b1;
          end else if ((state == ST_MOVE_DOWN) && below_valid) begin
            target_nxt = below_floor;
            tvalid_nxt = 1'b1;
          end else if (above_valid) begin
            state_nxt  = ST_MOVE_UP;
            dir_nxt    = DIR_UP;
            target_nxt = above_floor;
            tvalid_nxt = 1'b1;
          end else if (below_valid) begin
            state_nxt  = ST_MOVE_DOWN;
            dir_nxt    = DIR_DOWN;
            target_nxt = below_floor;
            tvalid_nxt = 1'b1;
          end else begin
            state_nxt  = ST_IDLE;
            dir_nxt    = DIR_IDLE;
            tvalid_nxt = 1'b0;
          end
        end

        ST_DWELL: begin
          door_nxt   = 1'b1;
          tvalid_nxt = 1'b0;
          if (call_here) begin
            cnt_nxt = DWELL_LOAD;
          end else if (dwell_cnt != '0) begin
            cnt_nxt = dwell_cnt - 1'b1;
          end else if ((dir == DIR_UP && above_valid) ||
                       (dir == DIR_DOWN && !below_valid && above_valid)) begin
            state_nxt  = ST_MOVE_UP;
            dir_nxt    = DIR_UP;
            target_nxt = above_floor;
            tvalid_nxt = 1'b1;
            door_nxt   = 1'b0;
          end else if ((dir == DIR_DOWN && below_valid) ||
                       (dir == DIR_UP && below_valid)) begin
            state_nxt  = ST_MOVE_DOWN;
            dir_nxt    = DIR_DOWN;
            target_nxt = below_floor;
            tvalid_nxt = 1'b1;
            door_nxt   = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
            dir_nxt   = DIR_IDLE;
            door_nxt  = 1'b0;
          end
        end

        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, dwell counter, latched calls and all outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= ST_IDLE;
      dwell_cnt    <= '0;
      target_floor <= FLOOR_W'(FLOOR_G);
      target_valid <= 1'b0;
      dir          <= DIR_IDLE;
      door_open    <= 1'b0;
      pending      <= '0;
      fault        <= 1'b0;
    end else begin
      state        <= state_nxt;
      dwell_cnt    <= cnt_nxt;
      target_floor <= target_nxt;
      target_valid <= tvalid_nxt;
      dir          <= dir_nxt;
      door_open    <= door_nxt;
      pending      <= pending_nxt;
      fault        <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb/tb_elevator_call_scheduler.sv - directed self-checking bench for the call scheduler
module tb_elevator_call_scheduler;

  logic       CLK;
  logic       reset;
  logic [8:1] call_req;
  logic [3:0] current_floor;
  logic       arrived;
  logic [3:0] target_floor;
  logic       target_valid;
  logic [1:0] dir;
  logic       door_open;
  logic [8:1] pending;
  logic       fault;

  int checks = 0;
  int errors = 0;

  elevator_call_scheduler #(
    .NUM_FLOORS   (8),
    .FLOOR_W      (4),
    .DWELL_CYCLES (4)
  ) dut (
    .CLK           (CLK),
    .reset         (reset),
    .call_req      (call_req),
    .current_floor (current_floor),
    .arrived       (arrived),
    .target_floor  (target_floor),
    .target_valid  (target_valid),
    .dir           (dir),
    .door_open     (door_open),
    .pending       (pending),
    .fault         (fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_target"}, 32'(target_floor), 32'h1);
    chk({tag, "_tvalid"}, 32'(target_valid), 32'h0);
    chk({tag, "_dir"},    32'(dir),          32'h0);
    chk({tag, "_door"},   32'(door_open),    32'h0);
    chk({tag, "_pend"},   32'(pending),      32'h0);
    chk({tag, "_fault"},  32'(fault),        32'h0);
  endtask

  initial begin
    reset = 1'b1;
    call_req = 8'h00;
    current_floor = 4'd1;
    arrived = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk_reset_values("reset");

    // Single call to floor 5 from ground.
    call_req = 8'h10;
    step();
    call_req = 8'h00;
    chk("t1_pend_lat", 32'(pending), 32'h10);
    chk("t1_tv_early", 32'(target_valid), 32'h0);
    step();
    chk("t1_tv",     32'(target_valid), 32'h1);
    chk("t1_target", 32'(target_floor), 32'h5);
    chk("t1_dir",    32'(dir),          32'h1);
    current_floor = 4'd2; step();
    current_floor = 4'd3; step();
    current_floor = 4'd4; step();
    current_floor = 4'd5; arrived = 1'b1; step();
    arrived = 1'b0;
    chk("t1_arr_tv",   32'(target_valid), 32'h0);
    chk("t1_arr_pend", 32'(pending),      32'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_door%0d", k), 32'(door_open), 32'h1);
      step();
    end
    chk("t1_door_end", 32'(door_open),    32'h0);
    chk("t1_dir_end",  32'(dir),          32'h0);
    chk("t1_tv_end",   32'(target_valid), 32'h0);
    chk("t1_fault",    32'(fault),        32'h0);

    // Pick-up en route: heading for 7 from floor 2, call at 4.
    current_floor = 4'd2;
    call_req = 8'h40; step();
    call_req = 8'h00; step();
    chk("t2_target7", 32'(target_floor), 32'h7);
    call_req = 8'h08; step();
    call_req = 8'h00; step();
    chk("t2_target4", 32'(target_floor), 32'h4);
    chk("t2_tv",      32'(target_valid), 32'h1);
    current_floor = 4'd3; step();
    current_floor = 4'd4; arrived = 1'b1; step();
    arrived = 1'b0;
    chk("t2_door",  32'(door_open), 32'h1);
    chk("t2_pend",  32'(pending),   32'h40);
    step(); step(); step();
    chk("t2_door_last", 32'(door_open), 32'h1);
    step();
    chk("t2_resume_tv",     32'(target_valid), 32'h1);
    chk("t2_resume_door",   32'(door_open),    32'h0);
    chk("t2_resume_target", 32'(target_floor), 32'h7);
    chk("t2_resume_dir",    32'(dir),          32'h1);

    // Reversal: calls at 2 and 8 while travelling up to 7.
    call_req = 8'h82; current_floor = 4'd5; step();
    call_req = 8'h00; current_floor = 4'd6; step();
    chk("t3_target_still7", 32'(target_floor), 32'h7);
    current_floor = 4'd7; arrived = 1'b1; step();
    arrived = 1'b0;
    chk("t3_pend_at7", 32'(pending), 32'h82);
    step(); step(); step(); step();
    chk("t3_up_target", 32'(target_floor), 32'h8);
    chk("t3_up_dir",    32'(dir),          32'h1);
    current_floor = 4'd8; arrived = 1'b1; step();
    arrived = 1'b0;
    chk("t3_pend_at8", 32'(pending), 32'h02);

    // Call at the current floor during the dwell reloads the door timer.
    step();
    call_req = 8'h80; step();
    call_req = 8'h00;
    chk("t5_pend_absorb", 32'(pending), 32'h02);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5_door%0d", k), 32'(door_open), 32'h1);
      step();
    end
    chk("t5_door_end",  32'(door_open),    32'h0);
    chk("t3_rev_tv",    32'(target_valid), 32'h1);
    chk("t3_rev_dir",   32'(dir),          32'h2);
    chk("t3_rev_target",32'(target_floor), 32'h2);

    // Arrival reported at a floor other than the target.
    current_floor = 4'd5; arrived = 1'b1; step();
    arrived = 1'b0;
    chk("t6_fault_arr", 32'(fault),        32'h1);
    chk("t6_tv_moving", 32'(target_valid), 32'h1);

    // Illegal floor code 0.
    current_floor = 4'd0; step();
    chk("t6_floor0_tv",    32'(target_valid), 32'h0);
    chk("t6_floor0_fault", 32'(fault),        32'h1);
    current_floor = 4'd3; step();
    chk("t6_recover_tv",     32'(target_valid), 32'h1);
    chk("t6_recover_target", 32'(target_floor), 32'h2);

    // Reset while moving.
    reset = 1'b1; step();
    chk_reset_values("midreset");
    reset = 1'b0;

    // Tie at floor 4 with calls at 2 and 6 goes up.
    current_floor = 4'd4;
    call_req = 8'h22; step();
    call_req = 8'h00; step();
    chk("t4_tie_tv",     32'(target_valid), 32'h1);
    chk("t4_tie_target", 32'(target_floor), 32'h6);
    chk("t4_tie_dir",    32'(dir),          32'h1);

    // Call and arrival for the same floor in one cycle: serviced, stays clear.
    current_floor = 4'd6; arrived = 1'b1; call_req = 8'h20; step();
    arrived = 1'b0; call_req = 8'h00;
    chk("t7_same_pend", 32'(pending),   32'h02);
    chk("t7_same_door", 32'(door_open), 32'h1);
    chk("t7_fault",     32'(fault),     32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Collects floor calls for an 8-floor car and runs a SCAN (collective) schedule. Hands one target floor at a time to the car motion/door datapath and holds the door open for a fixed dwell at each serviced floor. Sits between the floor-call switches and the motion block, which steps `current_floor` and reports arrival.

## Interface
- `NUM_FLOORS`, 8: number of floors. Floor codes run 1..NUM_FLOORS; code 1 is ground.
- `FLOOR_W`, 4: width of a floor code.
- `DWELL_CYCLES`, 16: CLK cycles the door stays open per stop. Must be ≥1.
- `CLK`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high reset.
- `call_req`  in  [NUM_FLOORS:1]: call inputs; bit i high for one or more cycles requests floor i.
- `current_floor`  in  FLOOR_W: floor code reported by the motion block.
- `arrived`  in  1: one-cycle pulse from the motion block when the car has stopped at `current_floor`.
- `target_floor`  out  FLOOR_W: floor the motion block must drive to.
- `target_valid`  out  1: `target_floor` is live; the motion block moves only while this is high.
- `dir`  out  2: travel direction. 00 IDLE, 01 UP, 10 DOWN.
- `door_open`  out  1: door command, high for the whole dwell.
- `pending`  out  [NUM_FLOORS:1]: latched, unserviced calls.
- `fault`  out  1: sticky error flag. Cleared only by `reset`.

## Operation
- Call latching:
  - `pending[i]` is set when `call_req[i]` is high.
  - `pending[i]` is cleared only on service of floor i.
  - Set wins over clear only when not in DWELL at floor i.
- States are IDLE, MOVE_UP, MOVE_DOWN and DWELL. `dir` is 00 in IDLE, 01 in MOVE_UP, 10 in MOVE_DOWN, and keeps its last value in DWELL.
- IDLE:
  - `pending[current_floor]` set → DWELL.
  - Otherwise, any pending call → move toward the nearest pending floor. Equal distance above and below → UP.
  - `target_floor` is set to the chosen floor.
- MOVE_UP:
  - `target_floor` = lowest pending floor strictly above `current_floor`.
  - It is re-evaluated every cycle, so a new call between the car and the target pulls the target closer.
- MOVE_DOWN: symmetric; `target_floor` = highest pending floor strictly below `current_floor`.
- `arrived` while `current_floor == target_floor` in MOVE_*:
  - Enter DWELL and clear `pending[target_floor]`.
  - Load the dwell counter with DWELL_CYCLES-1.
- `arrived` while `current_floor != target_floor`: set `fault` and otherwise ignore the pulse.
- DWELL:
  - `door_open`=1 and `target_valid`=0.
  - A new call at `current_floor` is absorbed: pending stays clear and the counter reloads.
  - Counter reaches 0 and a call exists in the stored direction → continue in that direction.
  - Else a call exists in the opposite direction → reverse.
  - Else → IDLE.
- `current_floor` = 0 or `current_floor` > NUM_FLOORS in any cycle → `fault`=1 and `target_valid` forced 0 that cycle.
- Floor arithmetic is unsigned FLOOR_W. Distance is computed as (a>b ? a-b : b-a) with no wrap-around. Floor 1 has no floor below it and floor NUM_FLOORS has no floor above it.

## Timing
- All outputs are registered.
- Reset values: `target_floor`=1, `target_valid`=0, `dir`=00, `door_open`=0, `pending`=0, `fault`=0, state IDLE, dwell counter 0.
- Latencies:
  - `call_req` → `pending`: 1 cycle.
  - `call_req` → `target_valid` from IDLE: 2 cycles.
  - Re-target after a new closer call: 2 cycles.
- `arrived` → `door_open`=1 and `target_valid`=0 on the next edge.
- `door_open` stays high for exactly DWELL_CYCLES cycles unless extended by a call at the current floor.
- First MOVE cycle after DWELL: `target_valid`=1 and `door_open`=0 on the same edge. The door is never open while `target_valid`=1.
- A call and an `arrived` for the same floor in the same cycle: the floor is serviced and `pending[i]` ends clear.
- `reset` mid-move or mid-dwell returns all state to reset values on that edge, including `pending`.

## Structure
- Package `elevator_pkg` holds:
  - NUM_FLOORS and FLOOR_W defaults.
  - Direction encoding: DIR_IDLE, DIR_UP, DIR_DOWN.
  - State enum.
  - Floor-code constants FLOOR_G=1 .. FLOOR_TOP.
- One combinational sub-module, `floor_select`. Inputs: `pending` and `current_floor`. Outputs:
  - nearest pending floor above, with a valid bit;
  - nearest pending floor below, with a valid bit;
  - `here` bit.
- The top-level FSM, latching and dwell counter use only `floor_select`.

## Test plan
- Single call, DWELL_CYCLES=4:
  - Stimulus: reset, `current_floor`=1, pulse `call_req[5]`.
  - Required: `target_valid`=1 with `target_floor`=5 and `dir`=01 two cycles later.
  - Then pulse `arrived` with `current_floor`=5 → `door_open` high for exactly 4 cycles, `pending`=0, state IDLE and `dir`=00 afterwards.
- Pick-up en route: moving UP toward 7 from floor 2, call 4 → `target_floor`=4 within 2 cycles. After the 4 dwell, the car resumes UP with `target_floor`=7.
- Reversal:
  - Stimulus: at floor 5, `pending`={2,8}, `dir` UP.
  - Required: service 8 first, then `dir`=10 with `target_floor`=2.
- Tie at floor 4 with calls {2,6} → UP chosen, `target_floor`=6.
- Call at current floor during DWELL → counter reloads, `door_open` extends to a full DWELL_CYCLES from that call, `pending` stays clear.
- Fault and reset:
  - `arrived` with `current_floor` ≠ `target_floor` → `fault` latches.
  - `current_floor`=0 → `fault`=1 and `target_valid`=0.
  - `reset` mid-move → all outputs return to reset values on the next edge.
